// File: rtl/mmu_pkg.sv
// Shared opcode and state encodings for the systolic GEMM engine.
package mmu_pkg;

  localparam logic [1:0] OpcodeClear   = 2'd0;
  localparam logic [1:0] OpcodeGemm    = 2'd1;
  localparam logic [1:0] OpcodeRead    = 2'd2;
  localparam logic [1:0] OpcodeIllegal = 2'd3;

  typedef enum logic [1:0] {
    OpClear   = OpcodeClear,
    OpGemm    = OpcodeGemm,
    OpRead    = OpcodeRead,
    OpIllegal = OpcodeIllegal
  } mmu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StReadout
  } mmu_state_e;

endpackage

// File: rtl/mmu_mac_pe.sv
// One output-stationary MAC cell: forwards data east and weight south, accumulates in place.
module mmu_mac_pe #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  input  logic [DATA_WIDTH-1:0] weight_i,
  input  logic                  weight_valid_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic [DATA_WIDTH-1:0] weight_o,
  output logic                  weight_valid_o,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic        [ACC_WIDTH-1:0]    acc_q;
  logic        [DATA_WIDTH-1:0]   data_q, weight_q;
  logic                           data_valid_q, weight_valid_q;

  assign prod = $signed(data_i) * $signed(weight_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_q          <= '0;
      data_q         <= '0;
      weight_q       <= '0;
      data_valid_q   <= 1'b0;
      weight_valid_q <= 1'b0;
    end else begin
      data_q         <= data_i;
      weight_q       <= weight_i;
      data_valid_q   <= data_valid_i;
      weight_valid_q <= weight_valid_i;
      if (clear_i) begin
        acc_q <= '0;
      end else if (data_valid_i && weight_valid_i) begin
        // Signed cast sign-extends the product; the sum wraps modulo 2^ACC_WIDTH.
        acc_q <= acc_q + ACC_WIDTH'(prod);
      end
    end
  end

  assign data_o         = data_q;
  assign data_valid_o   = data_valid_q;
  assign weight_o       = weight_q;
  assign weight_valid_o = weight_valid_q;
  assign acc_o          = acc_q;

endmodule

// File: rtl/mmu_systolic_array.sv
// ROWS x COLS output-stationary systolic GEMM engine with input skew, command FSM,
// automatic drain and back-pressured row readout.
module mmu_systolic_array
  import mmu_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned K_MAX      = 1024,
  localparam int unsigned KW = $clog2(K_MAX + 1),
  localparam int unsigned IW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_op_i,
  input  logic [KW-1:0]              cmd_k_i,
  input  logic                       cmd_accum_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [ROWS*DATA_WIDTH-1:0] data_i,
  input  logic [COLS*DATA_WIDTH-1:0] weight_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [COLS*ACC_WIDTH-1:0]  out_row_o,
  output logic [IW-1:0]              out_idx_o,
  output logic                       out_last_o,
  output logic                       busy_o,
  output logic                       err_o
);

  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_acc_width
    $error("ACC_WIDTH must be at least 2*DATA_WIDTH");
  end

  localparam int unsigned DrainLen = ROWS + COLS - 2;
  localparam int unsigned DCW      = (ROWS + COLS > 2) ? $clog2(ROWS + COLS) : 1;

  mmu_state_e       state_q;
  mmu_op_e          op;
  logic [KW-1:0]    beats_q, k_sat;
  logic [DCW-1:0]   drain_q;
  logic [IW-1:0]    idx_q;
  logic             err_q, cmd_fire, beat, clear_acc;

  assign op          = mmu_op_e'(cmd_op_i);
  assign cmd_ready_o = (state_q == StIdle);
  assign in_ready_o  = (state_q == StStream);
  assign out_valid_o = (state_q == StReadout);
  assign busy_o      = (state_q != StIdle);
  assign err_o       = err_q;
  assign out_idx_o   = idx_q;
  assign out_last_o  = out_valid_o && (idx_q == IW'(ROWS - 1));
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign beat        = in_valid_i && in_ready_o;
  assign k_sat       = (cmd_k_i > KW'(K_MAX)) ? KW'(K_MAX) : cmd_k_i;
  assign clear_acc   = cmd_fire && ((op == OpClear) || ((op == OpGemm) && !cmd_accum_i));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      beats_q <= '0;
      drain_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            unique case (op)
              OpClear: state_q <= StIdle;
              OpGemm: begin
                if (k_sat == '0) begin
                  state_q <= StReadout;
                end else begin
                  beats_q <= k_sat;
                  state_q <= StStream;
                end
              end
              OpRead:    state_q <= StReadout;
              OpIllegal: err_q   <= 1'b1;
              default:   err_q   <= 1'b1;
            endcase
          end
        end
        StStream: begin
          if (beat) begin
            beats_q <= beats_q - KW'(1);
            if (beats_q == KW'(1)) begin
              // A 1x1 array has nothing in flight after the last beat.
              if (DrainLen == 0) begin
                state_q <= StReadout;
              end else begin
                drain_q <= DCW'(DrainLen - 1);
                state_q <= StDrain;
              end
            end
          end
        end
        StDrain: begin
          if (drain_q == '0) state_q <= StReadout;
          else               drain_q <= drain_q - DCW'(1);
        end
        StReadout: begin
          if (out_ready_i) begin
            if (idx_q == IW'(ROWS - 1)) begin
              idx_q   <= '0;
              state_q <= StIdle;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Grid interconnect: a_h flows east along rows, b_v flows south along columns.
  logic [DATA_WIDTH-1:0] a_h  [ROWS][COLS+1];
  logic                  a_hv [ROWS][COLS+1];
  logic [DATA_WIDTH-1:0] b_v  [ROWS+1][COLS];
  logic                  b_vv [ROWS+1][COLS];
  logic [ACC_WIDTH-1:0]  acc  [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_data_skew
    if (r == 0) begin : g_direct
      assign a_h[0][0]  = data_i[0 +: DATA_WIDTH];
      assign a_hv[0][0] = beat;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] d_q [r];
      logic                  v_q [r];
      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          for (int i = 0; i < r; i++) begin
            d_q[i] <= '0;
            v_q[i] <= 1'b0;
          end
        end else begin
          d_q[0] <= data_i[r*DATA_WIDTH +: DATA_WIDTH];
          v_q[0] <= beat;
          for (int i = 1; i < r; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign a_h[r][0]  = d_q[r-1];
      assign a_hv[r][0] = v_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_weight_skew
    if (c == 0) begin : g_direct
      assign b_v[0][0]  = weight_i[0 +: DATA_WIDTH];
      assign b_vv[0][0] = beat;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] d_q [c];
      logic                  v_q [c];
      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          for (int i = 0; i < c; i++) begin
            d_q[i] <= '0;
            v_q[i] <= 1'b0;
          end
        end else begin
          d_q[0] <= weight_i[c*DATA_WIDTH +: DATA_WIDTH];
          v_q[0] <= beat;
          for (int i = 1; i < c; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign b_v[0][c]  = d_q[c-1];
      assign b_vv[0][c] = v_q[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      mmu_mac_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (clear_acc),
        .data_i         (a_h[r][c]),
        .data_valid_i   (a_hv[r][c]),
        .weight_i       (b_v[r][c]),
        .weight_valid_i (b_vv[r][c]),
        .data_o         (a_h[r][c+1]),
        .data_valid_o   (a_hv[r][c+1]),
        .weight_o       (b_v[r+1][c]),
        .weight_valid_o (b_vv[r+1][c]),
        .acc_o          (acc[r][c])
      );
    end
  end

  always_comb begin
    out_row_o = '0;
    for (int c = 0; c < COLS; c++) begin
      out_row_o[c*ACC_WIDTH +: ACC_WIDTH] = acc[idx_q][c];
    end
  end

endmodule

// File: doc/mmu_systolic_array.md
Name: mmu_systolic_array

Overview:
- Parametrised ROWS x COLS output-stationary systolic GEMM engine. It is the next generation of the fixed 4x4 MMU.
- Adds generated input skew for any size and a command FSM with a beat counter. Also adds automatic drain, optional accumulate-over-previous, and a back-pressured row-by-row result readout.
- Sits between the DMA/buffer front-end and the post-processing (BN/activation) stage.

Parameters:
- ROWS, 4, PE rows; number of data (A) lanes.
- COLS, 4, PE columns; number of weight (B) lanes.
- DATA_WIDTH, 16, signed operand width.
- ACC_WIDTH, 40, signed accumulator width. Elaboration error if ACC_WIDTH < 2*DATA_WIDTH.
- K_MAX, 1024, maximum beats per GEMM. KW = $clog2(K_MAX+1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&&ready.
- cmd_op_i  in  2  0=CLEAR, 1=GEMM, 2=READ, 3=illegal.
- cmd_k_i  in  KW  GEMM beat count; values above K_MAX are saturated to K_MAX.
- cmd_accum_i  in  1  GEMM: 1 = add onto existing accumulators, 0 = clear first.
- in_valid_i  in  1  operand beat valid.
- in_ready_o  out  1  operand beat ready.
- data_i  in  ROWS*DATA_WIDTH  A[:,k]; lane r at bits [r*DW +: DW].
- weight_i  in  COLS*DATA_WIDTH  B[k,:]; lane c at bits [c*DW +: DW].
- out_valid_o  out  1  result row valid.
- out_ready_i  in  1  result row ready.
- out_row_o  out  COLS*ACC_WIDTH  C[out_idx,:]; lane c at bits [c*AW +: AW].
- out_idx_o  out  $clog2(ROWS) (min 1)  row index.
- out_last_o  out  1  high with row ROWS-1.
- busy_o  out  1  state != IDLE.
- err_o  out  1  1-cycle pulse on acceptance of op 3.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - State goes to IDLE; all accumulators, skew registers, PE valid bits and counters go to 0.
  - Outputs after reset: cmd_ready_o=1, in_ready_o=0, out_valid_o=0, out_idx_o=0, out_last_o=0, busy_o=0, err_o=0.
  - Reset wins over every other event, including mid-STREAM, mid-DRAIN and mid-READOUT. Partial results are discarded.
- States: IDLE, STREAM, DRAIN, READOUT. cmd_ready_o=1 only in IDLE; commands offered in other states are not accepted.
- IDLE on accepted command:
  - CLEAR: accumulators zeroed at that edge; stay in IDLE.
  - GEMM with k>0: if accum=0, accumulators are zeroed at that edge. Load the beat counter with k and go to STREAM.
  - GEMM with k=0: accum=0 zeroes the accumulators. Go directly to READOUT.
  - READ: go to READOUT (re-read current accumulators).
  - op 3: err_o=1 next cycle; stay in IDLE.
- STREAM:
  - in_ready_o=1. Each accepted beat decrements the counter.
  - Gaps (in_valid_i=0) inject invalid bubbles. The array never stalls; skew and PE pipelines advance every cycle.
  - On the final accepted beat go to DRAIN; in_ready_o=0 from the next cycle.
- Skew:
  - Data lane r is delayed r registers; weight lane c is delayed c registers. Each lane carries its own valid bit.
  - PE(r,c) forwards data east and weight south through one register each, valid alongside.
- Timing: a beat accepted in cycle t updates acc(r,c) at the end of cycle t+r+c.
- DRAIN: lasts exactly ROWS+COLS-2 cycles, then READOUT. out_valid_o=1 exactly ROWS+COLS-1 cycles after the cycle of the last accepted beat (7 for 4x4).
- Arithmetic:
  - Signed product of width 2*DW, sign-extended to AW.
  - acc += product modulo 2^AW (wrap, no saturation). Invalid slots leave acc unchanged.
- READOUT:
  - out_valid_o=1, out_idx_o counts 0..ROWS-1, out_row_o = acc row out_idx.
  - While out_valid_o && !out_ready_i, all outputs are held stable.
  - The idx advances on handshake. The handshake on idx ROWS-1 (out_last_o=1) returns to IDLE.
  - Accumulators are not modified by readout.
- ROWS=1 or COLS=1: skew depth 0 on that side, DRAIN length follows the formula, single-row readout has out_last_o=1.

Decomposition:
- Shared package mmu_pkg holds:
  - mmu_op_e (CLEAR/GEMM/READ/ILLEGAL, 2 bits);
  - mmu_state_e (IDLE/STREAM/DRAIN/READOUT);
  - localparams for the opcode values.
- Sub-module mmu_mac_pe (one PE):
  - Ports: data/weight/valid in and out, a clear pulse, and acc out.
  - Generated ROWS x COLS times.
- The FSM, counters and skew chains live in the top module.

Test Plan:
- Reset: assert rst_i=0 for 2 cycles mid-STREAM of a k=8 GEMM -> next cycle cmd_ready_o=1, in_ready_o=0, out_valid_o=0. A following READ returns 4 rows of 0.
- Identity 4x4: GEMM k=4 accum=0, A=I, B=[1..16] row-major -> rows {1,2,3,4},{5,6,7,8},... out_valid_o rises 7 cycles after the last beat; out_last_o on idx 3.
- Back-pressure: same GEMM with out_ready_i=1,0,0,1,0,1,1 -> out_row_o/out_idx_o stable while stalled, exactly 4 handshakes, busy_o falls after the 4th.
- Accumulate and bubbles: repeat the identity GEMM with accum=1 and in_valid_i toggling 1,0,1,0 -> every element doubled (e.g. row0 {2,4,6,8}). Repeat with accum=0 -> single values.
- Signed wrap (DW=8, AW=16): A and B all -128, k=4 -> every acc = 65536 mod 2^16 = 0. With k=3 every acc = 49152 -> out lane reads 0xC000.
- Edge ops: GEMM k=0 accum=1 -> READOUT starts the next cycle with unchanged values. CLEAR then READ -> zeros. op 3 -> err_o high 1 cycle, state stays IDLE.
